// File: rtl/seq_loop_pkg.sv
// Shared definitions for the sequential-loop monitor.
// Contents:
//   state_t            - monitor FSM states (S_IDLE, S_LOOP, S_DONE)
//   ERR_W              - width of the sticky err_code vector
//   ERR_NO_ENTRY       - err_code bit: loop exit seen without a matching entry
//   ERR_FINISH_IN_LOOP - err_code bit: finish requested while inside the loop
//   ERR_STALL          - err_code bit: loop body stopped changing state
package seq_loop_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int ERR_W              = 3;
  localparam int ERR_NO_ENTRY       = 0;
  localparam int ERR_FINISH_IN_LOOP = 1;
  localparam int ERR_STALL          = 2;

endpackage

// File: rtl/seq_state_match.sv
// Combinational set-membership test for an FSM state.
// Parameters:
//   N         - number of entries in the set
//   FSM_WIDTH - width of one state encoding
// Ports:
//   state  in  FSM_WIDTH    state to look up
//   states in  N*FSM_WIDTH  packed set; entry i at [i*FSM_WIDTH +: FSM_WIDTH]
//   valid  in  N            per-entry valid mask; invalid entries never match
//   hit    out 1            state equals at least one valid entry
module seq_state_match #(
  parameter int N         = 1,
  parameter int FSM_WIDTH = 2
) (
  input  logic [FSM_WIDTH-1:0]   state,
  input  logic [N*FSM_WIDTH-1:0] states,
  input  logic [N-1:0]           valid,
  output logic                   hit
);

  // OR of per-entry equality, gated by the valid bit, so an all-zero mask
  // can never produce a hit.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (states[i*FSM_WIDTH +: FSM_WIDTH] == state)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_loop_monitor.sv
// Sequential-loop monitor: watches a DUT FSM state stream against a loop
// description and counts loop entries, per-entry iterations and exits, while
// flagging protocol violations. Transitions are judged on the pair
// (prev_state, cur_state), so every event is reported one cycle after the DUT
// transition shows up on cur_state.
//
// Build option: define SEQ_LOOP_STALL_CHECK_EN to build the stall checker
// (err_code[2]); without it err_code[2] is tied to 0.
//
// Ports:
//   clock                 in  sampling clock
//   reset                 in  asynchronous, active-low reset
//   cur_state             in  DUT current FSM state
//   pre_states_valid      in  valid mask for pre_loop_states
//   pre_loop_states       in  packed pre-loop states
//   post_states_valid     in  valid mask for post_loop_states
//   post_loop_states      in  packed post-loop states
//   quit_states_valid     in  valid mask for quit_loop_states
//   quit_loop_states      in  packed quit (exit-source) states
//   iter_start_state      in  first state of an iteration
//   iter_end_states_valid in  valid mask for iter_end_states
//   iter_end_states       in  packed iteration-end states
//   one_state_loop        in  loop body is the single state iter_start_state
//   finish                in  simulation finish request
//   in_loop               out monitor is in S_LOOP
//   iter_count            out iterations in the current entry (saturating)
//   last_trip             out iter_count frozen at the most recent exit
//   entry_count           out total loop entries (saturating)
//   err                   out OR of err_code
//   err_code              out sticky: [0] exit w/o entry, [1] finish in loop, [2] stall
//   done                  out finish acknowledged
module seq_loop_monitor
  import seq_loop_pkg::*;
#(
  parameter int FSM_WIDTH   = 2,
  parameter int N_PRE       = 3,
  parameter int N_POST      = 4,
  parameter int N_QUIT      = 3,
  parameter int N_ITER_END  = 1,
  parameter int CNT_WIDTH   = 32,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [FSM_WIDTH-1:0]              cur_state,
  input  logic [N_PRE-1:0]                  pre_states_valid,
  input  logic [N_PRE*FSM_WIDTH-1:0]        pre_loop_states,
  input  logic [N_POST-1:0]                 post_states_valid,
  input  logic [N_POST*FSM_WIDTH-1:0]       post_loop_states,
  input  logic [N_QUIT-1:0]                 quit_states_valid,
  input  logic [N_QUIT*FSM_WIDTH-1:0]       quit_loop_states,
  input  logic [FSM_WIDTH-1:0]              iter_start_state,
  input  logic [N_ITER_END-1:0]             iter_end_states_valid,
  input  logic [N_ITER_END*FSM_WIDTH-1:0]   iter_end_states,
  input  logic                              one_state_loop,
  input  logic                              finish,
  output logic                              in_loop,
  output logic [CNT_WIDTH-1:0]              iter_count,
  output logic [CNT_WIDTH-1:0]              last_trip,
  output logic [CNT_WIDTH-1:0]              entry_count,
  output logic                              err,
  output logic [ERR_W-1:0]                  err_code,
  output logic                              done
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state;
  state_t               state_next;
  logic [FSM_WIDTH-1:0] prev_state;

  logic pre_hit;
  logic post_hit;
  logic quit_hit;
  logic iter_end_hit;
  logic start_hit;

  logic enter_ok;
  logic exit_ok;
  logic iter_ok;

  logic do_enter;
  logic do_exit;
  logic do_iter;
  logic flag_no_entry;
  logic flag_finish_loop;
  logic stall_err;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Source states are looked up on prev_state, destination states on cur_state.
  seq_state_match #(.N(N_PRE), .FSM_WIDTH(FSM_WIDTH)) u_pre_match (
    .state(prev_state), .states(pre_loop_states), .valid(pre_states_valid), .hit(pre_hit)
  );

  seq_state_match #(.N(N_POST), .FSM_WIDTH(FSM_WIDTH)) u_post_match (
    .state(cur_state), .states(post_loop_states), .valid(post_states_valid), .hit(post_hit)
  );

  seq_state_match #(.N(N_QUIT), .FSM_WIDTH(FSM_WIDTH)) u_quit_match (
    .state(prev_state), .states(quit_loop_states), .valid(quit_states_valid), .hit(quit_hit)
  );

  seq_state_match #(.N(N_ITER_END), .FSM_WIDTH(FSM_WIDTH)) u_iter_end_match (
    .state(prev_state), .states(iter_end_states), .valid(iter_end_states_valid),
    .hit(iter_end_hit)
  );

  seq_state_match #(.N(1), .FSM_WIDTH(FSM_WIDTH)) u_start_match (
    .state(cur_state), .states(iter_start_state), .valid(1'b1), .hit(start_hit)
  );

  assign enter_ok = pre_hit && start_hit;
  assign exit_ok  = quit_hit && post_hit;
  // A one-state loop counts every cycle spent sitting on iter_start_state.
  assign iter_ok  = start_hit &&
                    (iter_end_hit || (one_state_loop && (prev_state == cur_state)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // finish outranks everything; inside the loop an exit outranks an
  // iteration that lands on the same cycle.
  always_comb begin
    state_next       = state;
    do_enter         = 1'b0;
    do_exit          = 1'b0;
    do_iter          = 1'b0;
    flag_no_entry    = 1'b0;
    flag_finish_loop = 1'b0;
    case (state)
      S_IDLE: begin
        if (finish) begin
          state_next = S_DONE;
        end else if (enter_ok) begin
          state_next = S_LOOP;
          do_enter   = 1'b1;
        end else if (exit_ok) begin
          flag_no_entry = 1'b1;
        end
      end
      S_LOOP: begin
        if (finish) begin
          state_next       = S_DONE;
          flag_finish_loop = 1'b1;
        end else if (exit_ok) begin
          state_next = S_IDLE;
          do_exit    = 1'b1;
        end else if (iter_ok) begin
          do_iter = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_DONE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Counters and sticky flags; the strobes are all low in S_DONE, which is
  // what freezes the counters there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_state  <= '0;
      iter_count  <= '0;
      last_trip   <= '0;
      entry_count <= '0;
      err_code    <= '0;
      done        <= 1'b0;
    end else begin
      prev_state <= cur_state;
      done       <= (state_next == S_DONE);
      if (do_enter) begin
        iter_count  <= CNT_ONE;
        entry_count <= sat_inc(entry_count);
      end else if (do_exit) begin
        last_trip  <= iter_count;
        iter_count <= '0;
      end else if (do_iter) begin
        iter_count <= sat_inc(iter_count);
      end
      if (flag_no_entry) begin
        err_code[ERR_NO_ENTRY] <= 1'b1;
      end
      if (flag_finish_loop) begin
        err_code[ERR_FINISH_IN_LOOP] <= 1'b1;
      end
      if (stall_err) begin
        err_code[ERR_STALL] <= 1'b1;
      end
    end
  end

`ifdef SEQ_LOOP_STALL_CHECK_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stall_run;

  // A stall cycle is one spent in the loop (and staying there) with no state
  // change, unless the loop body is legitimately a single state.
  assign stall_run = (state == S_LOOP) && (state_next == S_LOOP) &&
                     (cur_state == prev_state) && !one_state_loop;

  // Flag on the same edge that the count reaches the limit.
  assign stall_err = stall_run && (stall_cnt >= (STALL_MAX - STALL_ONE));

  // Counter saturates at the limit and clears as soon as the run breaks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!stall_run) begin
      stall_cnt <= '0;
    end else if (stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + STALL_ONE;
    end
  end
`else
  // No checker built. STALL_LIMIT is a positive count, so this is constant 0
  // while still referencing the parameter.
  assign stall_err = (STALL_LIMIT < 0);
`endif

  assign in_loop = (state == S_LOOP);
  assign err     = |err_code;

endmodule
